// File: rtl/gray_counter_ctrl_if.sv
// Command/status bundle between control logic and the Gray counter sequencer.
// Handshake: a command is taken on every rising edge where cmd_valid is high; there is no ready.
interface gray_counter_ctrl_if #(
    parameter int SIZE  = 16,
    parameter int LEN_W = 16
);
    localparam int W = (SIZE > 2) ? $clog2(SIZE) : 1;

    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             pause;

    logic             cnt_en;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             cmd_err;
    logic             wrap;
    logic [LEN_W-1:0] remaining;
    logic [W-1:0]     pos_bin;
    logic [W-1:0]     pos_gray;
    logic [1:0]       state_dbg;

    modport master (
        output cmd_valid, cmd_op, cmd_len, pause,
        input  cnt_en, cnt_clr, busy, done, aborted, cmd_err, wrap,
               remaining, pos_bin, pos_gray, state_dbg
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, pause,
        output cnt_en, cnt_clr, busy, done, aborted, cmd_err, wrap,
               remaining, pos_bin, pos_gray, state_dbg
    );
endinterface

// File: rtl/gray_counter_ctrl.sv
// Sequencer that steps an enable-driven Gray counter an exact number of times,
// mirroring its position in binary and Gray form.
module gray_counter_ctrl #(
    parameter int SIZE  = 16,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    gray_counter_ctrl_if.slave  bus
);
    localparam int W = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [W-1:0] LAST = W'(SIZE - 1);

    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_CLR  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] remaining, remaining_n;
    logic [W-1:0]     pos_bin, pos_n;
    logic [W-1:0]     pos_gray;
    logic             aborted, aborted_n;
    logic             cmd_err, cmd_err_n;
    logic             wrap, wrap_n;
    logic             cnt_en;
    logic             is_stop, is_start;

    assign cnt_en   = (state == S_RUN) && !bus.pause;
    assign is_stop  = bus.cmd_valid && (bus.cmd_op == OP_STOP);
    assign is_start = bus.cmd_valid && (bus.cmd_op != OP_STOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            pos_bin   <= '0;
            pos_gray  <= '0;
            aborted   <= 1'b0;
            cmd_err   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            pos_bin   <= pos_n;
            pos_gray  <= pos_n ^ (pos_n >> 1);
            aborted   <= aborted_n;
            cmd_err   <= cmd_err_n;
            wrap      <= wrap_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        pos_n       = pos_bin;
        aborted_n   = 1'b0;
        cmd_err_n   = 1'b0;
        wrap_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_RUN: begin
                            if (bus.cmd_len == '0) begin
                                state_n = S_DONE;
                            end else begin
                                remaining_n = bus.cmd_len;
                                state_n     = S_RUN;
                            end
                        end
                        OP_STEP: begin
                            remaining_n = LEN_W'(1);
                            state_n     = S_RUN;
                        end
                        OP_CLEAR: state_n = S_CLR;
                        default:  ;
                    endcase
                end
            end
            S_RUN: begin
                // The step taken on a STOP edge still counts; STOP then overrides the DONE move.
                if (cnt_en) begin
                    remaining_n = remaining - LEN_W'(1);
                    if (pos_bin == LAST) begin
                        pos_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        pos_n = pos_bin + W'(1);
                    end
                    if (remaining == LEN_W'(1)) state_n = S_DONE;
                end
                if (is_stop) begin
                    state_n     = S_IDLE;
                    remaining_n = '0;
                    aborted_n   = 1'b1;
                end else begin
                    cmd_err_n = is_start;
                end
            end
            S_DONE: begin
                state_n   = S_IDLE;
                cmd_err_n = is_start;
            end
            S_CLR: begin
                state_n   = S_IDLE;
                pos_n     = '0;
                cmd_err_n = is_start;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.cnt_en    = cnt_en;
    assign bus.cnt_clr   = (state == S_CLR);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.aborted   = aborted;
    assign bus.cmd_err   = cmd_err;
    assign bus.wrap      = wrap;
    assign bus.remaining = remaining;
    assign bus.pos_bin   = pos_bin;
    assign bus.pos_gray  = pos_gray;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Directed and random checks of gray_counter_ctrl against a behavioural model; a SIZE=16 and a
// SIZE=10 instance share one stimulus stream.
module tb_gray_counter_ctrl;
    localparam int SIZE_A = 16;
    localparam int SIZE_B = 10;
    localparam int LEN_W  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             pause = 1'b0;

    gray_counter_ctrl_if #(.SIZE(SIZE_A), .LEN_W(LEN_W)) bus_a ();
    gray_counter_ctrl_if #(.SIZE(SIZE_B), .LEN_W(LEN_W)) bus_b ();

    assign bus_a.cmd_valid = cmd_valid;
    assign bus_a.cmd_op    = cmd_op;
    assign bus_a.cmd_len   = cmd_len;
    assign bus_a.pause     = pause;
    assign bus_b.cmd_valid = cmd_valid;
    assign bus_b.cmd_op    = cmd_op;
    assign bus_b.cmd_len   = cmd_len;
    assign bus_b.pause     = pause;

    gray_counter_ctrl #(.SIZE(SIZE_A), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
    gray_counter_ctrl #(.SIZE(SIZE_B), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

    // Reference model: activity flags plus plain modular arithmetic on the position.
    bit m_run, m_done, m_clr, m_ab, m_err, m_wrap_a, m_wrap_b;
    int m_rem, m_pos_a, m_pos_b;
    int vectors = 0;
    int miscompares = 0;
    int obs_en = 0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_clr = 0; m_ab = 0; m_err = 0;
        m_wrap_a = 0; m_wrap_b = 0; m_rem = 0; m_pos_a = 0; m_pos_b = 0;
    endtask

    task automatic model_edge();
        bit en, start, stop;
        int old_rem;
        en    = m_run && !pause;
        stop  = cmd_valid && (cmd_op == 2'd2);
        start = cmd_valid && (cmd_op != 2'd2);
        m_ab = 0; m_err = 0; m_wrap_a = 0; m_wrap_b = 0;
        if (m_run) begin
            old_rem = m_rem;
            if (en) begin
                m_rem--;
                m_pos_a = (m_pos_a + 1) % SIZE_A;
                m_pos_b = (m_pos_b + 1) % SIZE_B;
                m_wrap_a = (m_pos_a == 0);
                m_wrap_b = (m_pos_b == 0);
            end
            if (stop) begin
                m_run = 0; m_rem = 0; m_ab = 1;
            end else begin
                m_err = start;
                if (en && old_rem == 1) begin m_run = 0; m_done = 1; end
            end
        end else if (m_done) begin
            m_done = 0; m_err = start;
        end else if (m_clr) begin
            m_clr = 0; m_pos_a = 0; m_pos_b = 0; m_err = start;
        end else if (cmd_valid) begin
            case (cmd_op)
                2'd0: if (cmd_len == 0) m_done = 1; else begin m_run = 1; m_rem = int'(cmd_len); end
                2'd1: begin m_run = 1; m_rem = 1; end
                2'd3: m_clr = 1;
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        check("busy",      bus_a.busy,      m_run | m_done | m_clr);
        check("done",      bus_a.done,      m_done);
        check("cnt_clr",   bus_a.cnt_clr,   m_clr);
        check("aborted",   bus_a.aborted,   m_ab);
        check("cmd_err",   bus_a.cmd_err,   m_err);
        check("wrap",      bus_a.wrap,      m_wrap_a);
        check("remaining", bus_a.remaining, m_rem);
        check("pos_bin",   bus_a.pos_bin,   m_pos_a);
        check("pos_gray",  bus_a.pos_gray,  gray(m_pos_a));
        check("b_wrap",     bus_b.wrap,     m_wrap_b);
        check("b_pos_bin",  bus_b.pos_bin,  m_pos_b);
        check("b_pos_gray", bus_b.pos_gray, gray(m_pos_b));
        check("b_busy",     bus_b.busy,     m_run | m_done | m_clr);
    endtask

    task automatic tick();
        #1;
        check("cnt_en",   bus_a.cnt_en, m_run && !pause);
        check("b_cnt_en", bus_b.cnt_en, m_run && !pause);
        if (bus_a.cnt_en === 1'b1) obs_en++;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        pause = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_cnt_en", bus_a.cnt_en, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic cmd(input logic [1:0] op, input int len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((m_run | m_done | m_clr) && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", (m_run | m_done | m_clr), 1'b0);
    endtask

    initial begin
        // 1: reset, RUN 5 without pause
        do_reset();
        obs_en = 0;
        cmd(2'd0, 5);
        wait_idle(20);
        check("t1_enables", obs_en, 5);
        check("t1_gray", bus_a.pos_gray, 32'd7);

        // 2: wrap 15 -> 0 on the SIZE=16 instance
        do_reset();
        cmd(2'd0, 14);
        wait_idle(40);
        cmd(2'd0, 3);
        wait_idle(20);
        check("t2_pos", bus_a.pos_bin, 32'd1);
        check("t2_gray", bus_a.pos_gray, 32'd1);

        // 3: pause in the middle of RUN 4
        do_reset();
        obs_en = 0;
        cmd(2'd0, 4);
        tick();
        pause = 1'b1;
        tick();
        tick();
        check("t3_frozen", bus_a.remaining, 32'd3);
        pause = 1'b0;
        wait_idle(20);
        check("t3_enables", obs_en, 4);

        // 4: STOP after three enables, step on the STOP edge counts
        do_reset();
        cmd(2'd0, 10);
        tick();
        tick();
        tick();
        cmd(2'd2, 0);
        check("t4_pos", bus_a.pos_bin, 32'd4);
        check("t4_aborted", bus_a.aborted, 1'b1);
        check("t4_idle", bus_a.busy, 1'b0);
        tick();
        tick();

        // 5: RUN while busy is rejected; RUN 0 goes straight to done
        do_reset();
        obs_en = 0;
        cmd(2'd0, 6);
        tick();
        cmd(2'd0, 2);
        check("t5_err", bus_a.cmd_err, 1'b1);
        wait_idle(20);
        check("t5_enables", obs_en, 6);
        obs_en = 0;
        cmd(2'd0, 0);
        check("t5_done0", bus_a.done, 1'b1);
        tick();
        check("t5_no_en", obs_en, 0);
        cmd(2'd1, 0);
        wait_idle(5);

        // 6: CLEAR at position 9, then asynchronous reset mid-RUN
        do_reset();
        cmd(2'd0, 9);
        wait_idle(20);
        check("t6_pos9", bus_a.pos_bin, 32'd9);
        cmd(2'd3, 0);
        check("t6_clr", bus_a.cnt_clr, 1'b1);
        cmd(2'd0, 3);
        check("t6_clr_err", bus_a.cmd_err, 1'b1);
        check("t6_pos0", bus_a.pos_bin, 32'd0);
        cmd(2'd0, 20);
        tick();
        tick();
        do_reset();

        // Random command stream
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_len   = LEN_W'($urandom_range(0, 12));
            pause     = ($urandom_range(0, 3) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        pause = 1'b0;
        wait_idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
